// File: rtl/dmem_stall_gen.sv
// dmem_stall_gen: MEM-stage data memory sequencer.
// Issues one bus access per load/store and stalls the pipe until it retires.
module dmem_stall_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_type,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              hold_i,
  output logic              mem_stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              addr_err_o,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              is_b, is_h, is_w;
  logic              acc_vld, mis, go, err_d;
  logic [DATA_W-1:0] wdata_d;
  logic [3:0]        wstrb_d;

  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              ld_b, ld_h, ld_w;
  logic [DATA_W-1:0] lane, ext;

  assign is_b = (mem_size == 2'b00);
  assign is_h = (mem_size == 2'b01);
  assign is_w = mem_size[1];

  assign acc_vld = ((mem_type == 2'b01) |
                    (mem_type == 2'b10)) & ~flush;
  assign mis = (is_h & mem_addr[0]) |
               (is_w & (|mem_addr[1:0]));

  assign go    = (state_q == IDLE) & acc_vld & ~mis;
  assign err_d = (state_q == IDLE) & acc_vld & mis;

  assign mem_stall_o = go | (state_q == REQ) |
                       (state_q == WAIT);
  assign bus_req_valid = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go) state_d = REQ;
      REQ:  if (bus_req_ready) state_d = WAIT;
      WAIT: if (bus_resp_valid) state_d = DONE;
      DONE: if (!hold_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Replicate store data across lanes so the bus only needs wstrb.
  always_comb begin
    wdata_d = mem_wdata;
    wstrb_d = 4'b1111;
    unique case (1'b1)
      is_b: begin
        wdata_d = {4{mem_wdata[7:0]}};
        wstrb_d = 4'b0001 << mem_addr[1:0];
      end
      is_h: begin
        wdata_d = {2{mem_wdata[15:0]}};
        wstrb_d = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      is_w: begin
        wdata_d = mem_wdata;
        wstrb_d = 4'b1111;
      end
    endcase
  end

  assign ld_b = (size_q == 2'b00);
  assign ld_h = (size_q == 2'b01);
  assign ld_w = size_q[1];
  assign lane = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = lane;
    unique case (1'b1)
      ld_b: ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
      ld_h: ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
      ld_w: ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_err_o <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= 4'b0000;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      rdata_o    <= '0;
    end else begin
      state_q    <= state_d;
      addr_err_o <= err_d;
      if (go) begin
        bus_we    <= (mem_type == 2'b10);
        bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
        bus_wdata <= wdata_d;
        bus_wstrb <= wstrb_d;
        off_q     <= mem_addr[1:0];
        size_q    <= mem_size;
        sgn_q     <= mem_signed;
      end
      if ((state_q == WAIT) && bus_resp_valid && !bus_we)
        rdata_o <= ext;
    end
  end

endmodule

// File: tb/tb_dmem_stall_gen.sv
// tb_dmem_stall_gen: directed vectors and corner sequences
// for the MEM-stage data memory sequencer.
module tb_dmem_stall_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_type, mem_size;
  logic        mem_signed;
  logic [31:0] mem_addr, mem_wdata;
  logic        flush, hold_i;
  logic        mem_stall_o;
  logic [31:0] rdata_o;
  logic        addr_err_o;
  logic        bus_req_valid, bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_stall_gen dut (
    .clk           (clk),
    .rst           (rst),
    .mem_type      (mem_type),
    .mem_size      (mem_size),
    .mem_signed    (mem_signed),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .flush         (flush),
    .hold_i        (hold_i),
    .mem_stall_o   (mem_stall_o),
    .rdata_o       (rdata_o),
    .addr_err_o    (addr_err_o),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_resp_valid(bus_resp_valid),
    .bus_rdata     (bus_rdata)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] brd;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_strb;
    logic        exp_we;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic xact(input vec_t v,
                      input int rdy_at,
                      input int hold_n,
                      input bit flush_mid,
                      output int stalls,
                      output int reqs,
                      output bit stable_ok,
                      output bit tmo);
    bit got;
    stalls = 0;
    reqs = 0;
    stable_ok = 1'b1;
    tmo = 1'b0;
    got = 1'b0;
    @(posedge clk); #1;
    mem_type = v.typ;
    mem_size = v.sz;
    mem_signed = v.sgn;
    mem_addr = v.addr;
    mem_wdata = v.wd;
    flush = 1'b0;
    hold_i = 1'b0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (mem_stall_o) stalls++;
      if (bus_req_valid) begin
        reqs++;
        if (bus_addr !== v.exp_addr ||
            bus_wdata !== v.exp_wd ||
            bus_wstrb !== v.exp_strb ||
            bus_we !== v.exp_we)
          stable_ok = 1'b0;
        mem_addr = v.addr ^ 32'h0000_0F0F;
        mem_wdata = ~v.wd;
        if (flush_mid) flush = 1'b1;
        if (reqs == rdy_at) begin
          bus_req_ready = 1'b1;
          got = 1'b1;
          break;
        end
      end
    end
    if (!got) tmo = 1'b1;
    @(negedge clk);
    if (mem_stall_o) stalls++;
    if (bus_req_valid) reqs++;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b1;
    bus_rdata = v.brd;
    @(negedge clk);
    if (mem_stall_o) stalls++;
    if (bus_req_valid) reqs++;
    bus_resp_valid = 1'b0;
    bus_rdata = 32'h0;
    flush = 1'b0;
    mem_addr = v.addr;
    hold_i = (hold_n > 0);
    if (hold_n == 0) mem_type = 2'b00;
    for (int h = 0; h < hold_n; h++) begin
      @(negedge clk);
      if (mem_stall_o) stalls++;
      if (bus_req_valid) reqs++;
      if (h == hold_n - 1) begin
        hold_i = 1'b0;
        mem_type = 2'b00;
      end
    end
    @(negedge clk);
    if (mem_stall_o) stalls++;
    if (bus_req_valid) reqs++;
  endtask

  task automatic misal(input string nm,
                       input logic [1:0] typ,
                       input logic [1:0] sz,
                       input logic [31:0] addr);
    int errs, stl, rq;
    errs = 0;
    stl = 0;
    rq = 0;
    @(posedge clk); #1;
    mem_type = typ;
    mem_size = sz;
    mem_addr = addr;
    mem_wdata = 32'h1111_2222;
    flush = 1'b0;
    @(negedge clk);
    errs += int'(addr_err_o);
    stl += int'(mem_stall_o);
    rq += int'(bus_req_valid);
    @(posedge clk); #1;
    mem_type = 2'b00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      errs += int'(addr_err_o);
      stl += int'(mem_stall_o);
      rq += int'(bus_req_valid);
    end
    chk({nm, "_err_pulses"}, 32'(errs), 32'd1);
    chk({nm, "_stall"}, 32'(stl), 32'd0);
    chk({nm, "_req"}, 32'(rq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, rq, nst, nrq, nerr;
    bit ok, tmo;
    vec_t v;

    tbl[0] = '{2'b01, 2'b10, 1'b0, 32'h100, 32'h0,
               32'hDEADBEEF, 32'hDEADBEEF,
               32'h100, 32'h0, 4'b1111, 1'b0};
    tbl[1] = '{2'b01, 2'b00, 1'b1, 32'h103, 32'h0,
               32'h80112233, 32'hFFFFFF80,
               32'h100, 32'h0, 4'b1000, 1'b0};
    tbl[2] = '{2'b01, 2'b00, 1'b0, 32'h103, 32'h0,
               32'h80112233, 32'h00000080,
               32'h100, 32'h0, 4'b1000, 1'b0};
    tbl[3] = '{2'b01, 2'b01, 1'b1, 32'h102, 32'h0,
               32'hABCD1234, 32'hFFFFABCD,
               32'h100, 32'h0, 4'b1100, 1'b0};
    tbl[4] = '{2'b01, 2'b01, 1'b0, 32'h100, 32'h0,
               32'hABCD8765, 32'h00008765,
               32'h100, 32'h0, 4'b0011, 1'b0};
    tbl[5] = '{2'b01, 2'b00, 1'b1, 32'h201, 32'h0,
               32'h00007F00, 32'h0000007F,
               32'h200, 32'h0, 4'b0010, 1'b0};
    tbl[6] = '{2'b10, 2'b00, 1'b0, 32'h302, 32'h000000A5,
               32'h99999999, 32'h0000007F,
               32'h300, 32'hA5A5A5A5, 4'b0100, 1'b1};
    tbl[7] = '{2'b10, 2'b10, 1'b0, 32'h304, 32'hCAFEF00D,
               32'h99999999, 32'h0000007F,
               32'h304, 32'hCAFEF00D, 4'b1111, 1'b1};
    tbl[8] = '{2'b01, 2'b11, 1'b1, 32'h408, 32'h0,
               32'h13579BDF, 32'h13579BDF,
               32'h408, 32'h0, 4'b1111, 1'b0};

    rst = 1'b0;
    mem_type = 2'b00;
    mem_size = 2'b00;
    mem_signed = 1'b0;
    mem_addr = 32'h0;
    mem_wdata = 32'h0;
    flush = 1'b0;
    hold_i = 1'b0;
    bus_req_ready = 1'b0;
    bus_resp_valid = 1'b0;
    bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_req", 32'(bus_req_valid), 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", 32'(addr_err_o), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);

    for (int i = 0; i < 9; i++) begin
      xact(tbl[i], 1, 0, 1'b0, st, rq, ok, tmo);
      chk($sformatf("v%0d_tmo", i), 32'(tmo), 32'd0);
      chk($sformatf("v%0d_stall", i), 32'(st), 32'd3);
      chk($sformatf("v%0d_reqs", i), 32'(rq), 32'd1);
      chk($sformatf("v%0d_bus", i), 32'(ok), 32'd1);
      chk($sformatf("v%0d_rdata", i), rdata_o,
          tbl[i].exp_rd);
    end

    v = '{2'b10, 2'b01, 1'b0, 32'h202, 32'h00001234,
          32'h77777777, 32'h13579BDF,
          32'h200, 32'h12341234, 4'b1100, 1'b1};
    xact(v, 4, 0, 1'b0, st, rq, ok, tmo);
    chk("sh_tmo", 32'(tmo), 32'd0);
    chk("sh_stall", 32'(st), 32'd6);
    chk("sh_req_cycles", 32'(rq), 32'd4);
    chk("sh_stable", 32'(ok), 32'd1);
    chk("sh_rdata_kept", rdata_o, 32'h13579BDF);

    misal("lw101", 2'b01, 2'b10, 32'h101);
    misal("lh203", 2'b01, 2'b01, 32'h203);
    misal("sw302", 2'b10, 2'b10, 32'h302);

    v = '{2'b01, 2'b10, 1'b0, 32'h500, 32'h0,
          32'h0BADF00D, 32'h0BADF00D,
          32'h500, 32'h0, 4'b1111, 1'b0};
    xact(v, 1, 2, 1'b1, st, rq, ok, tmo);
    chk("hold_tmo", 32'(tmo), 32'd0);
    chk("hold_stall", 32'(st), 32'd3);
    chk("hold_reqs", 32'(rq), 32'd1);
    chk("hold_rdata", rdata_o, 32'h0BADF00D);

    nst = 0;
    nrq = 0;
    nerr = 0;
    @(posedge clk); #1;
    mem_type = 2'b01;
    mem_size = 2'b10;
    mem_addr = 32'h700;
    flush = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nst += int'(mem_stall_o);
      nrq += int'(bus_req_valid);
      nerr += int'(addr_err_o);
      if (c == 1) begin
        flush = 1'b0;
        mem_type = 2'b11;
      end
    end
    mem_type = 2'b00;
    chk("flush_none_stall", 32'(nst), 32'd0);
    chk("flush_none_req", 32'(nrq), 32'd0);
    chk("flush_none_err", 32'(nerr), 32'd0);

    @(posedge clk); #1;
    mem_type = 2'b01;
    mem_size = 2'b10;
    mem_addr = 32'h600;
    bus_req_ready = 1'b1;
    @(negedge clk);
    chk("rw_idle_stall", 32'(mem_stall_o), 32'd1);
    @(negedge clk);
    chk("rw_req", 32'(bus_req_valid), 32'd1);
    @(posedge clk); #1;
    mem_type = 2'b00;
    bus_req_ready = 1'b0;
    @(negedge clk);
    chk("rw_wait_stall", 32'(mem_stall_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("rw_rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rw_rst_rdata", rdata_o, 32'h0);
    chk("rw_rst_addr", bus_addr, 32'h0);
    chk("rw_rst_req", 32'(bus_req_valid), 32'd0);
    bus_resp_valid = 1'b1;
    bus_rdata = 32'h5555AAAA;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    chk("rw_late_rdata", rdata_o, 32'h0);
    chk("rw_late_stall", 32'(mem_stall_o), 32'd0);
    chk("rw_late_req", 32'(bus_req_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_stall_gen.md
DMEM_STALL_GEN -- requirements
Module: dmem_stall_gen

Interface
REQ-001 The block SHALL have one clock domain; reset is asynchronous and active-low.
REQ-002 Parameter: ADDR_W, default 32, byte address width.
REQ-003 Parameter: DATA_W, default 32, bus data width; only 32 is supported.
REQ-004 clk  input  1  pipeline clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 mem_type  input  2  MEM-stage access type: 2'b00 none, 2'b01 LOAD, 2'b10 STOR, 2'b11 treated as none.
REQ-007 mem_size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 mem_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 mem_addr  input  ADDR_W  byte address.
REQ-010 mem_wdata  input  32  store data, right-aligned.
REQ-011 flush  input  1  pipeline flush; suppresses the issue of a new access.
REQ-012 hold_i  input  1  pipeline held by another stall source.
REQ-013 mem_stall_o  output  1  stall request to the stall controller (mem_stall_i there).
REQ-014 rdata_o  output  32  extended load result, registered.
REQ-015 addr_err_o  output  1  misaligned-access pulse.
REQ-016 bus_req_valid  output  1  bus request valid.
REQ-017 bus_req_ready  input  1  bus accepts request.
REQ-018 bus_we  output  1  1 means write.
REQ-019 bus_addr  output  ADDR_W  word-aligned address (low two bits forced to 0).
REQ-020 bus_wdata  output  32  lane-replicated store data.
REQ-021 bus_wstrb  output  4  byte enables.
REQ-022 bus_resp_valid  input  1  response strobe, for both reads and writes.
REQ-023 bus_rdata  input  32  read word.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-025 An access is valid when mem_type is LOAD or STOR and flush is 0.
REQ-026 Misalignment is defined as a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-027 IDLE: on a valid, aligned access, the block SHALL latch we, bus_addr, bus_wdata and bus_wstrb, then go to REQ.
REQ-028 IDLE: on a valid, misaligned access, the block SHALL pulse addr_err_o for 1 cycle, issue no bus request, and stay in IDLE.
REQ-029 REQ: bus_req_valid=1 and outputs are held stable until bus_req_ready; on ready the FSM SHALL go to WAIT.
REQ-030 WAIT: on bus_resp_valid the FSM SHALL go to DONE; for a load, it SHALL also register the extended lane data into rdata_o.
REQ-031 DONE: the FSM SHALL go to IDLE when hold_i=0 and stay in DONE while hold_i=1, so an access is never re-issued.
REQ-032 mem_stall_o SHALL be combinational: 1 in REQ and WAIT, and 1 in IDLE when a valid aligned access is present; 0 otherwise, including in DONE.
REQ-033 The minimum stall is 3 cycles (IDLE, REQ with ready=1, WAIT with response on the next cycle); DONE follows with stall=0.
REQ-034 Store data SHALL be replicated: byte into all 4 lanes, half into both halves; wstrb per size and addr[1:0] (e.g. byte at offset 2 gives 4'b0100).
REQ-035 Load data SHALL be selected by latched addr[1:0] and size, then sign- or zero-extended to 32 bits.
REQ-036 Flush in REQ, WAIT or DONE SHALL NOT abort the access; it completes normally.
REQ-037 bus_resp_valid in IDLE or REQ SHALL be ignored.
REQ-038 rdata_o SHALL be unchanged by stores.

Reset
REQ-039 On rst=0, the FSM SHALL go to IDLE immediately, regardless of the current state.
REQ-040 On rst=0, bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, rdata_o and addr_err_o SHALL all be 0.
REQ-041 A reset mid-access SHALL abandon the transaction; a late bus_resp_valid after reset SHALL be ignored.

Verification
REQ-042 Load word at 0x100, ready=1 immediately, rdata 0xDEADBEEF one cycle later -> stall high 3 cycles, DONE stall=0, rdata_o=0xDEADBEEF.
REQ-043 Signed byte load at 0x103, bus_rdata 0x80112233 -> rdata_o=0xFFFFFF80; the unsigned case gives 0x00000080.
REQ-044 Store half 0x1234 at 0x202, ready delayed 4 cycles -> bus_wstrb=4'b1100, bus_wdata=0x12341234, stable throughout REQ, stall for 6 cycles.
REQ-045 Word load at 0x101 -> addr_err_o pulses 1 cycle, bus_req_valid stays 0, stall=0.
REQ-046 hold_i=1 for 2 cycles in DONE -> the FSM stays in DONE and exactly one bus request is issued; flush with mem_type=LOAD in IDLE -> no request, stall=0.
REQ-047 rst asserted in WAIT, then bus_resp_valid pulses -> state IDLE, rdata_o=0, stall=0.
